// File: rtl/rvvi_tx_scheduler_if.sv
// Handshake bundle between the RVVI TX scheduler, the packetizer (fresh
// packets) and the MAC transmit port.
//   master : scheduler side (accepts fresh packets, drives TX)
//   slave  : environment side (packetizer source and MAC sink)
interface rvvi_tx_scheduler_if #(
    parameter int WIDTH = 792
);
    logic             NewValid;
    logic [WIDTH-1:0] NewData;
    logic             NewReady;
    logic [WIDTH-1:0] TxData;
    logic             TxValid;
    logic             TxReady;

    modport master (
        input  NewValid,
        input  NewData,
        input  TxReady,
        output NewReady,
        output TxData,
        output TxValid
    );

    modport slave (
        output NewValid,
        output NewData,
        output TxReady,
        input  NewReady,
        input  TxData,
        input  TxValid
    );
endinterface

// File: rtl/rvvi_tx_scheduler.sv
// RVVI TX scheduler: shares the single Ethernet TX packet slot between fresh
// trace packets (admitted into the active list as they launch) and replay
// packets read back from the active list. It also runs an ack watchdog that
// raises a sticky lost-ack flag.
//
// Optional feature macro RVVI_TX_STATS_EN: when defined, adds NewCount and
// ReplayCount statistics outputs (wrapping counters of width CNTW).
module rvvi_tx_scheduler #(
    parameter int WIDTH   = 792,
    parameter int TIMEOUT = 4096,
    parameter int CNTW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    rvvi_tx_scheduler_if.master bus,
    output logic              ALPort1Wen,
    input  logic              ALFull,
    input  logic              ALEmpty,
    input  logic              ALWait,
    input  logic [WIDTH-1:0]  ReplayData,
    input  logic              ReplayValid,
    output logic              ReplayStall,
    input  logic              AckSeen,
    output logic              AckTimeout
`ifdef RVVI_TX_STATS_EN
    ,
    output logic [CNTW-1:0]   NewCount,
    output logic [CNTW-1:0]   ReplayCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_NEW    = 2'd1,
        S_REPLAY = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int             WDW    = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

    state_t             state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic               ack_timeout_q, ack_timeout_d;

    logic               slot_free;
    logic               new_ready_fsm;
    logic               replay_stall_fsm;
    logic               new_load;
    logic               replay_load;

    // The TX register can take a packet when empty or when its current one leaves.
    assign slot_free = ~tx_valid_q | bus.TxReady;

    // While reset is held, nothing is accepted and replay stays stalled.
    assign new_load    = new_ready_fsm & ~reset;
    assign ReplayStall = replay_stall_fsm | reset;
    assign replay_load = ReplayValid & ~ReplayStall;

    assign bus.NewReady = new_load;
    assign ALPort1Wen   = bus.NewValid & new_load;
    assign bus.TxData   = tx_data_q;
    assign bus.TxValid  = tx_valid_q;
    assign AckTimeout   = ack_timeout_q;

    // Scheduler FSM: next state plus acceptance/stall controls.
    always_comb begin
        state_d          = state_q;
        new_ready_fsm    = 1'b0;
        replay_stall_fsm = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ALWait) begin
                    state_d = S_REPLAY;
                end else begin
                    state_d = S_NEW;
                end
            end
            S_NEW: begin
                // A pending replay blocks fresh traffic the same cycle it shows up.
                new_ready_fsm = bus.NewValid & slot_free & ~ALFull & ~ALWait;
                if (ALWait) begin
                    state_d = S_REPLAY;
                end else begin
                    state_d = S_NEW;
                end
            end
            S_REPLAY: begin
                replay_stall_fsm = ~slot_free;
                // Leave when the pass ends, or when the list has nothing more
                // to offer even though we are ready (waiting on acks).
                if (~ALWait || (~ReplayValid && slot_free)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_REPLAY;
                end
            end
            S_DRAIN: begin
                if (ALWait && ReplayValid) begin
                    state_d = S_REPLAY;
                end else if (~ALWait && ~tx_valid_q) begin
                    state_d = S_NEW;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single-stage TX register: load on accept, clear on consume, else hold.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (new_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.NewData;
        end else if (replay_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ReplayData;
        end else if (bus.TxReady) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end
    end

    // Ack watchdog: saturating count of ack-less cycles with a non-empty list.
    always_comb begin
        if (AckSeen || ALEmpty) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + WDW'(1);
        end
        ack_timeout_d = ack_timeout_q | (wd_d == WD_MAX);
    end

    // State, TX register and watchdog flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            wd_q          <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            wd_q          <= wd_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

`ifdef RVVI_TX_STATS_EN
    logic [CNTW-1:0] new_count_q, new_count_d;
    logic [CNTW-1:0] replay_count_q, replay_count_d;

    assign NewCount    = new_count_q;
    assign ReplayCount = replay_count_q;

    // Statistics: count admitted fresh packets and replay loads, wrapping.
    always_comb begin
        if (ALPort1Wen) begin
            new_count_d = new_count_q + CNTW'(1);
        end else begin
            new_count_d = new_count_q;
        end
        if (replay_load) begin
            replay_count_d = replay_count_q + CNTW'(1);
        end else begin
            replay_count_d = replay_count_q;
        end
    end

    // Statistics counter flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            new_count_q    <= '0;
            replay_count_q <= '0;
        end else begin
            new_count_q    <= new_count_d;
            replay_count_q <= replay_count_d;
        end
    end
`endif

endmodule
